// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: PC-1/PC-2 tables, rotation schedule, state enum and helpers.
// Tables use DES bit numbering: bit 1 is the MSB of the vector being permuted.
package des_pkg;

  localparam int unsigned KEY_W    = 64;
  localparam int unsigned CD_W     = 56;
  localparam int unsigned HALF_W   = CD_W / 2;
  localparam int unsigned SUBKEY_W = 48;
  localparam int unsigned ROUNDS   = 16;
  localparam int unsigned ROUND_W  = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned PC1_TAB [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TAB [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam logic [1:0] SHIFT [ROUNDS] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Drops the eight parity bits and reorders the key into {C,D}.
  function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] key);
    logic [CD_W-1:0] cd;
    cd = '0;
    for (int i = 0; i < int'(CD_W); i++) begin
      cd[6'(int'(CD_W) - 1 - i)] = key[6'(KEY_W - PC1_TAB[i])];
    end
    return cd;
  endfunction

  function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]}
                       : {x[HALF_W-2:0], x[HALF_W-1]};
  endfunction

  function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[1:0], x[HALF_W-1:2]}
                       : {x[0], x[HALF_W-1:1]};
  endfunction

  // High when any byte of the key has even parity (DES wants odd parity per byte).
  function automatic logic key_parity_bad(input logic [KEY_W-1:0] key);
    logic bad;
    bad = 1'b0;
    for (int b = 0; b < int'(KEY_W / 8); b++) begin
      bad = bad | ~(^key[b*8 +: 8]);
    end
    return bad;
  endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// Key-offer and subkey-stream handshake bundle for des_key_schedule.
interface des_key_schedule_if;
  import des_pkg::*;

  logic [KEY_W-1:0]    key_i;
  logic                decrypt_i;
  logic                key_valid_i;
  logic                key_ready_o;
  logic [SUBKEY_W-1:0] subkey_o;
  logic                subkey_valid_o;
  logic                subkey_ready_i;
  logic [ROUND_W-1:0]  round_o;
  logic                done_o;
  logic                parity_err_o;

  modport master (
    output key_i, decrypt_i, key_valid_i, subkey_ready_i,
    input  key_ready_o, subkey_o, subkey_valid_o, round_o, done_o, parity_err_o
  );

  modport slave (
    input  key_i, decrypt_i, key_valid_i, subkey_ready_i,
    output key_ready_o, subkey_o, subkey_valid_o, round_o, done_o, parity_err_o
  );
endinterface

// File: rtl/des_pc2.sv
// Combinational DES PC-2 permutation: 56-bit {C,D} to 48-bit round key.
module des_pc2
  import des_pkg::*;
(
  input  logic [CD_W-1:0]     cd,
  output logic [SUBKEY_W-1:0] subkey
);

  for (genvar i = 0; i < int'(SUBKEY_W); i++) begin : g_bit
    assign subkey[SUBKEY_W-1-i] = cd[CD_W - PC2_TAB[i]];
  end

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES round-key generator, one 48-bit subkey per handshake in encrypt or decrypt order.
// Optional key parity flag enabled by defining DES_KEY_PARITY_CHECK_EN.
module des_key_schedule
  import des_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  des_key_schedule_if.slave bus
);

  state_t              state;
  logic [HALF_W-1:0]   c;
  logic [HALF_W-1:0]   d;
  logic [ROUND_W-1:0]  round;
  logic                mode;
  logic                key_ready;
  logic                subkey_valid;
  logic                done;
  logic [CD_W-1:0]     cd_init;
  logic [SUBKEY_W-1:0] subkey;

  assign cd_init = pc1(bus.key_i);

  des_pc2 u_pc2 (
    .cd     ({c, d}),
    .subkey (subkey)
  );

  // Decrypt loads PC1(key) unrotated: the 28 total shifts bring it back, so K16 is first.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      c            <= '0;
      d            <= '0;
      round        <= '0;
      mode         <= 1'b0;
      key_ready    <= 1'b1;
      subkey_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.key_valid_i) begin
            mode         <= bus.decrypt_i;
            round        <= '0;
            state        <= RUN;
            key_ready    <= 1'b0;
            subkey_valid <= 1'b1;
            if (bus.decrypt_i) begin
              c <= cd_init[CD_W-1:HALF_W];
              d <= cd_init[HALF_W-1:0];
            end else begin
              c <= rotl28(cd_init[CD_W-1:HALF_W], SHIFT[0]);
              d <= rotl28(cd_init[HALF_W-1:0], SHIFT[0]);
            end
          end
        end
        RUN: begin
          if (bus.subkey_ready_i) begin
            if (round == ROUND_W'(ROUNDS - 1)) begin
              state        <= IDLE;
              round        <= '0;
              done         <= 1'b1;
              key_ready    <= 1'b1;
              subkey_valid <= 1'b0;
            end else begin
              round <= round + ROUND_W'(1);
              if (mode) begin
                c <= rotr28(c, SHIFT[ROUND_W'(ROUNDS - 1) - round]);
                d <= rotr28(d, SHIFT[ROUND_W'(ROUNDS - 1) - round]);
              end else begin
                c <= rotl28(c, SHIFT[round + ROUND_W'(1)]);
                d <= rotl28(d, SHIFT[round + ROUND_W'(1)]);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DES_KEY_PARITY_CHECK_EN
  logic parity_err;

  // Flag is informational only; it is refreshed on every accepted key.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      parity_err <= 1'b0;
    end else if (state == IDLE && bus.key_valid_i) begin
      parity_err <= key_parity_bad(bus.key_i);
    end
  end

  assign bus.parity_err_o = parity_err;
`else
  assign bus.parity_err_o = 1'b0;
`endif

  assign bus.key_ready_o    = key_ready;
  assign bus.subkey_valid_o = subkey_valid;
  assign bus.subkey_o       = subkey;
  assign bus.round_o        = round;
  assign bus.done_o         = done;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule using the classic 0x133457799BBCDFF1 key schedule.
module tb_des_key_schedule;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [47:0] ks [16];

  localparam logic [63:0] KEY_GOOD = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_BAD  = 64'h123457799BBCDFF1;
`ifdef DES_KEY_PARITY_CHECK_EN
  localparam logic PAR_EXP = 1'b1;
`else
  localparam logic PAR_EXP = 1'b0;
`endif

  des_key_schedule_if kif ();

  des_key_schedule dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [63:0] key, input logic dec);
    kif.key_i          = key;
    kif.decrypt_i      = dec;
    kif.key_valid_i    = 1'b1;
    kif.subkey_ready_i = 1'b1;
    chk("acc_key_ready_before", 48'(kif.key_ready_o), 48'(1));
    @(negedge clk);
    kif.key_valid_i = 1'b0;
    chk("acc_subkey_valid", 48'(kif.subkey_valid_o), 48'(1));
    chk("acc_key_ready_after", 48'(kif.key_ready_o), 48'(0));
  endtask

  // Walks all 16 rounds from round 0; optional stall and optional key offer during RUN.
  task automatic stream(input logic dec, input int bp_at, input int spoof_at);
    logic [47:0] exp;
    for (int r = 0; r < 16; r++) begin
      exp = dec ? ks[15-r] : ks[r];
      chk($sformatf("round_idx_%0d", r), 48'(kif.round_o), 48'(r));
      chk($sformatf("subkey_r%0d", r), kif.subkey_o, exp);
      chk($sformatf("valid_r%0d", r), 48'(kif.subkey_valid_o), 48'(1));
      if (r == spoof_at) begin
        kif.key_i       = 64'h0;
        kif.decrypt_i   = 1'b1;
        kif.key_valid_i = 1'b1;
      end
      if (r == bp_at) begin
        kif.subkey_ready_i = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_round", 48'(kif.round_o), 48'(r));
          chk("stall_subkey", kif.subkey_o, exp);
          chk("stall_done", 48'(kif.done_o), 48'(0));
        end
        kif.subkey_ready_i = 1'b1;
      end
      @(negedge clk);
    end
    chk("end_done", 48'(kif.done_o), 48'(1));
    chk("end_key_ready", 48'(kif.key_ready_o), 48'(1));
    chk("end_round", 48'(kif.round_o), 48'(0));
    if (spoof_at < 0) chk("end_valid", 48'(kif.subkey_valid_o), 48'(0));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    ks = '{
      48'b000110_110000_001011_101111_111111_000111_000001_110010,
      48'b011110_011010_111011_011001_110110_111100_100111_100101,
      48'b010101_011111_110010_001010_010000_101100_111110_011001,
      48'b011100_101010_110111_010110_110110_110011_010100_011101,
      48'b011111_001110_110000_000111_111010_110101_001110_101000,
      48'b011000_111010_010100_111110_010100_000111_101100_101111,
      48'b111011_001000_010010_110111_111101_100001_100010_111100,
      48'b111101_111000_101000_111010_110000_010011_101111_111011,
      48'b111000_001101_101111_101011_111011_011110_011110_000001,
      48'b101100_011111_001101_000111_101110_100100_011001_001111,
      48'b001000_010101_111111_010011_110111_101101_001110_000110,
      48'b011101_010111_000111_110101_100101_000110_011111_101001,
      48'b100101_111100_010111_010001_111110_101011_101001_000001,
      48'b010111_110100_001110_110111_111100_101110_011100_111010,
      48'b101111_111001_000110_001101_001111_010011_111100_001010,
      48'b110010_110011_110110_001011_000011_100001_011111_110101
    };
    rst_n              = 1'b0;
    kif.key_i          = '0;
    kif.decrypt_i      = 1'b0;
    kif.key_valid_i    = 1'b0;
    kif.subkey_ready_i = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_key_ready", 48'(kif.key_ready_o), 48'(1));
    chk("rst_subkey_valid", 48'(kif.subkey_valid_o), 48'(0));
    chk("rst_done", 48'(kif.done_o), 48'(0));
    chk("rst_round", 48'(kif.round_o), 48'(0));
    chk("rst_subkey", kif.subkey_o, 48'h0);
    chk("rst_parity", 48'(kif.parity_err_o), 48'(0));
    kif.subkey_ready_i = 1'b1;
    @(negedge clk);
    chk("idle_ready_no_effect", 48'(kif.subkey_valid_o), 48'(0));
    rst_n = 1'b1;
    @(negedge clk);

    chk("k1_hex", ks[0], 48'h1B02EFFC7072);
    chk("k2_hex", ks[1], 48'h79AED9DBC9E5);
    chk("k16_hex", ks[15], 48'hCB3D8B0E17F5);

    accept(KEY_GOOD, 1'b0);
    stream(1'b0, -1, -1);
    accept(KEY_GOOD, 1'b1);
    stream(1'b1, -1, -1);
    accept(KEY_GOOD, 1'b0);
    stream(1'b0, 3, -1);

    // Key 0 offered during RUN must wait for the IDLE cycle that carries done.
    accept(KEY_GOOD, 1'b0);
    stream(1'b0, -1, 2);
    chk("spoof_key_ready_idle", 48'(kif.key_ready_o), 48'(1));
    @(negedge clk);
    kif.key_valid_i = 1'b0;
    kif.decrypt_i   = 1'b0;
    chk("spoof_accepted_valid", 48'(kif.subkey_valid_o), 48'(1));
    chk("spoof_accepted_ready", 48'(kif.key_ready_o), 48'(0));
    chk("spoof_done_cleared", 48'(kif.done_o), 48'(0));
    for (int r = 0; r < 16; r++) begin
      chk("zero_key_round", 48'(kif.round_o), 48'(r));
      chk("zero_key_subkey", kif.subkey_o, 48'h0);
      @(negedge clk);
    end
    chk("zero_key_done", 48'(kif.done_o), 48'(1));

    // Asynchronous reset in the middle of a schedule.
    accept(KEY_GOOD, 1'b0);
    repeat (7) @(negedge clk);
    chk("pre_rst_round", 48'(kif.round_o), 48'(7));
    chk("pre_rst_subkey", kif.subkey_o, ks[7]);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_key_ready", 48'(kif.key_ready_o), 48'(1));
    chk("mid_rst_valid", 48'(kif.subkey_valid_o), 48'(0));
    chk("mid_rst_round", 48'(kif.round_o), 48'(0));
    chk("mid_rst_subkey", kif.subkey_o, 48'h0);
    chk("mid_rst_done", 48'(kif.done_o), 48'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    accept(KEY_GOOD, 1'b0);
    stream(1'b0, -1, -1);

    chk("parity_good", 48'(kif.parity_err_o), 48'(0));
    accept(KEY_BAD, 1'b0);
    chk("parity_bad", 48'(kif.parity_err_o), 48'(PAR_EXP));
    stream(1'b0, -1, -1);
    chk("parity_bad_held", 48'(kif.parity_err_o), 48'(PAR_EXP));
    accept(KEY_GOOD, 1'b0);
    chk("parity_cleared", 48'(kif.parity_err_o), 48'(0));
    stream(1'b0, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
